// File: rtl/arith_shift_left_seq.sv
// -----------------------------------------------------------------------------
// arith_shift_left_seq
//   Iterative signed arithmetic left shifter. A start strobe captures a signed
//   operand and a shift amount. The operand then moves left by one bit per
//   clock, with zeros filling the LSB. When the count runs out, the result is
//   presented together with a one-cycle done pulse and an overflow flag.
//   Overflow means the result no longer equals a*2**value in W bits. It is
//   detected on each step as a change of the sign bit, and it stays set for the
//   rest of the operation.
//
// Ports
//   clk    in   1   single clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request, sampled only while idle
//   a      in   W   signed operand, captured with start
//   value  in   SW  shift amount, captured with start
//   busy   out  1   high while an operation is shifting or completing
//   done   out  1   one-cycle pulse when y/ovf are updated
//   y      out  W   signed result, held until the next done
//   ovf    out  1   overflow of the operation, held with y
//
// Configuration
//   ASL_SATURATE_EN  when defined, an overflowed result saturates toward the
//                    sign of the original operand instead of wrapping.
// -----------------------------------------------------------------------------
module arith_shift_left_seq #(
   parameter int W  = 8,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [SW-1:0] value,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  y,
   output logic          ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic          ovf_int_q, ovf_int_d;
   logic [W-1:0]  y_q, y_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
`ifdef ASL_SATURATE_EN
   // The sign of the original operand selects the saturation rail, because
   // acc may already have lost that sign by the time overflow is detected.
   logic          sign_q, sign_d;
`endif

   // The next-state and datapath logic. Every register holds its value unless
   // the current state says otherwise. done defaults low so that it is a pulse.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_int_d = ovf_int_q;
      y_d       = y_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
`ifdef ASL_SATURATE_EN
      sign_d    = sign_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d     = a;
               cnt_d     = value;
               ovf_int_d = 1'b0;
`ifdef ASL_SATURATE_EN
               sign_d    = a[W-1];
`endif
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            if (cnt_q != '0) begin
               // A step overflows when the bit about to become the sign
               // differs from the current sign.
               acc_d     = {acc_q[W-2:0], 1'b0};
               cnt_d     = cnt_q - SW'(1);
               ovf_int_d = ovf_int_q | (acc_q[W-1] ^ acc_q[W-2]);
            end else begin
`ifdef ASL_SATURATE_EN
               if (ovf_int_q) begin
                  y_d = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
               end else begin
                  y_d = acc_q;
               end
`else
               y_d = acc_q;
`endif
               ovf_d   = ovf_int_q;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The state and data registers. A reset discards any operation in flight
   // and clears the visible result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_int_q <= 1'b0;
         y_q       <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef ASL_SATURATE_EN
         sign_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_int_q <= ovf_int_d;
         y_q       <= y_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
`ifdef ASL_SATURATE_EN
         sign_q    <= sign_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign y    = y_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_arith_shift_left_seq.sv
// -----------------------------------------------------------------------------
// tb_arith_shift_left_seq
//   Self-checking bench for arith_shift_left_seq (W=8, SW=3). A behavioural
//   model predicts busy/done/y/ovf from plain integer arithmetic. Each accepted
//   operation is simply a*2**value checked against the signed 8-bit range. A
//   compare process checks the DUT against that model on every cycle. Directed
//   operations also pin literal results and latencies.
// -----------------------------------------------------------------------------
module tb_arith_shift_left_seq;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [SW-1:0] value;
   logic          busy;
   logic          done;
   logic [W-1:0]  y;
   logic          ovf;

   int checks   = 0;
   int failures = 0;
   bit checkEn  = 1'b0;

   // Model state: whether an operation is in progress, how many edges have
   // passed since it was accepted, and the held result.
   bit           mActive = 1'b0;
   int           mT      = 0;
   int           mA      = 0;
   int           mV      = 0;
   bit           mDone   = 1'b0;
   logic [W-1:0] mY      = '0;
   bit           mOvf    = 1'b0;

   arith_shift_left_seq #(.W(W), .SW(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .value (value),
      .busy  (busy),
      .done  (done),
      .y     (y),
      .ovf   (ovf)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Records one comparison. Any mismatch is reported on a single FAIL line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural reference. An accepted operation finishes value+1 edges after
   // its start edge with y = a*2**value. That result wraps to W bits, or
   // saturates in the saturating build. It overflows exactly when the true
   // product is outside the signed W-bit range. The model goes idle one edge
   // later.
   always @(posedge clk) begin
      int prod;
      if (!rst_n) begin
         mActive = 1'b0;
         mDone   = 1'b0;
         mY      = '0;
         mOvf    = 1'b0;
      end else if (!mActive) begin
         mDone = 1'b0;
         if (start) begin
            mActive = 1'b1;
            mT      = 0;
            mA      = int'($signed(a));
            mV      = int'(value);
         end
      end else begin
         mT++;
         if (mT == mV + 1) begin
            prod = mA * (1 << mV);
            mOvf = (prod > 127) || (prod < -128);
`ifdef ASL_SATURATE_EN
            if (mOvf) mY = (mA < 0) ? 8'h80 : 8'h7F;
            else      mY = prod[W-1:0];
`else
            mY = prod[W-1:0];
`endif
            mDone = 1'b1;
         end else if (mT == mV + 2) begin
            mActive = 1'b0;
            mDone   = 1'b0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model. Outputs are
   // sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy", 32'(busy), 32'(mActive));
         checkOutput("done", 32'(done), 32'(mDone));
         checkOutput("y",    32'(y),    32'(mY));
         checkOutput("ovf",  32'(ovf),  32'(mOvf));
      end
   end

   // Issues one operation and waits, with a bound, for its done pulse. It
   // returns the number of sampled cycles up to and including the done cycle,
   // and how many of those cycles had busy high. It then waits one more cycle,
   // so that the DUT is idle again before the next request.
   task automatic applyStimulus(input logic [W-1:0] ta, input logic [SW-1:0] tv,
                                output int lat, output int busyCycles);
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      value = tv;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busyCycles = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) busyCycles++;
      end
      if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      checkOutput("busy_after_op", 32'(busy), 32'd0);
   endtask

   int lat, bc, doneCount;
   logic [W-1:0] yAtDone;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      value = '0;
      repeat (2) @(negedge clk);
      checkEn = 1'b1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_y",    32'(y),    32'd0);
      checkOutput("reset_ovf",  32'(ovf),  32'd0);
      rst_n = 1'b1;

      // Basic shift: 3 << 4 = 48, with done on the 6th sampled cycle.
      applyStimulus(8'd3, 3'd4, lat, bc);
      checkOutput("t1_y", 32'(y), 32'd48);
      checkOutput("t1_ovf", 32'(ovf), 32'd0);
      checkOutput("t1_latency", 32'(lat), 32'd6);
      checkOutput("t1_busy_cycles", 32'(bc), 32'd6);

      // Negative operand: -1 << 1 = -2.
      applyStimulus(8'hFF, 3'd1, lat, bc);
      checkOutput("t2_y", 32'(y), 32'hFE);
      checkOutput("t2_ovf", 32'(ovf), 32'd0);

      // Positive overflow.
      applyStimulus(8'd64, 3'd3, lat, bc);
      checkOutput("t3a_ovf", 32'(ovf), 32'd1);
`ifdef ASL_SATURATE_EN
      checkOutput("t3a_y", 32'(y), 32'h7F);
`else
      checkOutput("t3a_y", 32'(y), 32'h00);
`endif

      // Negative overflow.
      applyStimulus(8'h80, 3'd2, lat, bc);
      checkOutput("t3b_ovf", 32'(ovf), 32'd1);
`ifdef ASL_SATURATE_EN
      checkOutput("t3b_y", 32'(y), 32'h80);
`else
      checkOutput("t3b_y", 32'(y), 32'h00);
`endif

      // Zero shift: done on the 2nd sampled cycle and y = a.
      applyStimulus(8'hFB, 3'd0, lat, bc);
      checkOutput("t4a_y", 32'(y), 32'hFB);
      checkOutput("t4a_ovf", 32'(ovf), 32'd0);
      checkOutput("t4a_latency", 32'(lat), 32'd2);
      applyStimulus(8'd0, 3'd7, lat, bc);
      checkOutput("t4b_y", 32'(y), 32'd0);
      checkOutput("t4b_ovf", 32'(ovf), 32'd0);
      checkOutput("t4b_latency", 32'(lat), 32'd9);

      // A start while busy is ignored: only one done, with 1 << 5.
      @(negedge clk);
      start = 1'b1; a = 8'd1; value = 3'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 8'd9; value = 3'd1;
      @(negedge clk);
      start = 1'b0;
      doneCount = 0;
      yAtDone = '0;
      repeat (15) begin
         @(negedge clk);
         if (done) begin
            doneCount++;
            yAtDone = y;
         end
      end
      checkOutput("t5_done_count", 32'(doneCount), 32'd1);
      checkOutput("t5_y", 32'(yAtDone), 32'd32);

      // A reset mid-shift discards the operation.
      @(negedge clk);
      start = 1'b1; a = 8'd64; value = 3'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      doneCount = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("t6_done_count", 32'(doneCount), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_y", 32'(y), 32'd0);
      checkOutput("t6_ovf", 32'(ovf), 32'd0);
      applyStimulus(8'd2, 3'd1, lat, bc);
      checkOutput("t6_next_y", 32'(y), 32'd4);

      // Random traffic, including starts while busy and occasional resets. It
      // is checked purely by the every-cycle compare process.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         a     = W'($urandom);
         value = SW'($urandom);
         rst_n = ($urandom_range(0, 59) != 0);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
